// File: rtl/mult32x32_fast_ctrl.sv
// Sequences the 16x16-multiplier datapath to build a 64-bit product of two 32-bit operands.
// Partial products whose operand MSW is zero are skipped when SKIP_ZERO is set.
module mult32x32_fast_ctrl #(
   parameter int SKIP_ZERO = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       a_msw_is_0,
   input  logic       b_msw_is_0,
   output logic       busy,
   output logic       done,
   output logic       a_sel,
   output logic       b_sel,
   output logic [1:0] shift_sel,
   output logic       upd_prod,
   output logic       clr_prod,
   output logic [2:0] steps
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      P00  = 3'd1,
      P01  = 3'd2,
      P10  = 3'd3,
      P11  = 3'd4,
      DONE = 3'd5
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic [2:0] cnt;
   logic [2:0] cnt_nxt;
   logic       za;
   logic       zb;

   assign za = a_msw_is_0 && (SKIP_ZERO != 0);
   assign zb = b_msw_is_0 && (SKIP_ZERO != 0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= 3'd0;
         steps <= 3'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (state_nxt == DONE) begin
            steps <= cnt;
         end
      end
   end

   // Flags are only consulted in the state being left; operands are held stable by the requester.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = P00;
               cnt_nxt   = 3'd1;
            end
         end
         P00: begin
            if (!zb) begin
               state_nxt = P01;
            end else if (!za) begin
               state_nxt = P10;
            end else begin
               state_nxt = DONE;
            end
         end
         P01:     state_nxt = za ? DONE : P10;
         P10:     state_nxt = zb ? DONE : P11;
         P11:     state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (state != IDLE && state_nxt inside {P01, P10, P11}) begin
         cnt_nxt = cnt + 3'd1;
      end
   end

   always_comb begin
      busy      = 1'b0;
      done      = 1'b0;
      a_sel     = 1'b0;
      b_sel     = 1'b0;
      shift_sel = 2'b00;
      upd_prod  = 1'b0;
      clr_prod  = 1'b0;
      case (state)
         IDLE: clr_prod = start && reset;
         P00: begin
            busy     = 1'b1;
            upd_prod = 1'b1;
         end
         P01: begin
            busy      = 1'b1;
            b_sel     = 1'b1;
            shift_sel = 2'b01;
            upd_prod  = 1'b1;
         end
         P10: begin
            busy      = 1'b1;
            a_sel     = 1'b1;
            shift_sel = 2'b01;
            upd_prod  = 1'b1;
         end
         P11: begin
            busy      = 1'b1;
            a_sel     = 1'b1;
            b_sel     = 1'b1;
            shift_sel = 2'b10;
            upd_prod  = 1'b1;
         end
         DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   a_no_hazard: assert property (@(posedge clk) disable iff (!reset) !(upd_prod && clr_prod));
   a_no_shift3: assert property (@(posedge clk) disable iff (!reset) shift_sel != 2'b11);

endmodule

// File: tb/tb_mult32x32_fast_ctrl.sv
// Bench for mult32x32_fast_ctrl: one instance with skipping, one without, each driving a datapath model.
module tb_mult32x32_fast_ctrl;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [31:0]  a;
   logic [31:0]  b;
   logic         a_msw_is_0;
   logic         b_msw_is_0;
   logic [1:0]   busy_v, done_v, a_sel_v, b_sel_v, upd_v, clr_v;
   logic [3:0]   shift_all;
   logic [5:0]   steps_all;
   logic [127:0] prod_all;

   always #5 clk = ~clk;

   assign a_msw_is_0 = (a[31:16] == 16'h0);
   assign b_msw_is_0 = (b[31:16] == 16'h0);

   for (genvar g = 0; g < 2; g++) begin : g_inst
      logic [15:0] ah, bh;
      logic [31:0] pp;
      logic [63:0] prod;

      mult32x32_fast_ctrl #(.SKIP_ZERO(g == 0 ? 1 : 0)) u_dut (
         .clk        (clk),
         .reset      (reset),
         .start      (start),
         .a_msw_is_0 (a_msw_is_0),
         .b_msw_is_0 (b_msw_is_0),
         .busy       (busy_v[g]),
         .done       (done_v[g]),
         .a_sel      (a_sel_v[g]),
         .b_sel      (b_sel_v[g]),
         .shift_sel  (shift_all[g*2 +: 2]),
         .upd_prod   (upd_v[g]),
         .clr_prod   (clr_v[g]),
         .steps      (steps_all[g*3 +: 3])
      );

      assign ah = a_sel_v[g] ? a[31:16] : a[15:0];
      assign bh = b_sel_v[g] ? b[31:16] : b[15:0];
      assign pp = {16'h0, ah} * {16'h0, bh};
      assign prod_all[g*64 +: 64] = prod;

      always @(posedge clk or negedge reset) begin
         if (!reset)          prod <= 64'h0;
         else if (clr_v[g])   prod <= 64'h0;
         else if (upd_v[g])   prod <= prod + ({32'h0, pp} << {shift_all[g*2 +: 2], 4'b0000});
      end
   end

   typedef struct {
      logic [63:0] prod;
      int          steps;
      int          done_cyc;
   } exp_t;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] prod;
      int          steps;
      bit          poke;
      string       name;
   } vec_t;

   int         errs = 0;
   int         checks = 0;
   int         cyc;
   bit         mon_en;
   string      wname;
   int         clr_cnt[2], done_cnt[2], busy_cnt[2], exp_busy[2], ops[2];
   bit         hazard[2];
   logic [3:0] sq0[$], sq1[$];
   exp_t       eq0[$], eq1[$];
   vec_t       vecs[6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errs++;
      $display("FAIL %s", name);
   endtask

   // Steps visited follow directly from which operand halves may be skipped.
   function automatic int model_steps(input logic [31:0] ma, input logic [31:0] mb, input bit skip);
      bit nza, nzb;
      nza = !skip || (ma[31:16] != 16'h0);
      nzb = !skip || (mb[31:16] != 16'h0);
      return 1 + int'(nzb) + int'(nza) + int'(nza && nzb);
   endfunction

   task automatic expect_op(input logic [31:0] ea, input logic [31:0] eb, input logic [63:0] p,
                            input int steps0, input int start_cyc);
      for (int g = 0; g < 2; g++) begin
         bit   skip, nza, nzb;
         exp_t e;
         logic [3:0] seq[$];
         skip = (g == 0);
         nza  = !skip || (ea[31:16] != 16'h0);
         nzb  = !skip || (eb[31:16] != 16'h0);
         seq.push_back(4'b0000);
         if (nzb)         seq.push_back(4'b0101);
         if (nza)         seq.push_back(4'b1001);
         if (nza && nzb)  seq.push_back(4'b1110);
         e.prod     = p;
         e.steps    = skip ? steps0 : 4;
         e.done_cyc = start_cyc + 1 + e.steps;
         foreach (seq[i]) begin
            if (g == 0) sq0.push_back(seq[i]);
            else        sq1.push_back(seq[i]);
         end
         if (g == 0) eq0.push_back(e);
         else        eq1.push_back(e);
         exp_busy[g] += e.steps + 1;
         ops[g]++;
      end
   endtask

   task automatic sample(input int g);
      logic [3:0] code, want;
      exp_t       e;
      bit         got;
      code = {a_sel_v[g], b_sel_v[g], shift_all[g*2 +: 2]};
      if (clr_v[g]) clr_cnt[g]++;
      if (clr_v[g] && upd_v[g]) hazard[g] = 1'b1;
      if (busy_v[g]) busy_cnt[g]++;
      if (upd_v[g]) begin
         got = 1'b0;
         if (g == 0 && sq0.size() > 0) begin want = sq0.pop_front(); got = 1'b1; end
         if (g == 1 && sq1.size() > 0) begin want = sq1.pop_front(); got = 1'b1; end
         if (got) chk($sformatf("%s sel/shift[%0d] cyc%0d", wname, g, cyc), 64'(code), 64'(want));
         else     fail($sformatf("%s unexpected upd_prod[%0d] cyc%0d", wname, g, cyc));
      end
      if (done_v[g]) begin
         done_cnt[g]++;
         got = 1'b0;
         if (g == 0 && eq0.size() > 0) begin e = eq0.pop_front(); got = 1'b1; end
         if (g == 1 && eq1.size() > 0) begin e = eq1.pop_front(); got = 1'b1; end
         if (got) begin
            chk($sformatf("%s product[%0d]", wname, g), prod_all[g*64 +: 64], e.prod);
            chk($sformatf("%s steps[%0d]", wname, g), 64'(steps_all[g*3 +: 3]), 64'(e.steps));
            chk($sformatf("%s done_cycle[%0d]", wname, g), 64'(cyc), 64'(e.done_cyc));
         end else begin
            fail($sformatf("%s unexpected done[%0d] cyc%0d", wname, g, cyc));
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      if (mon_en) begin
         for (int g = 0; g < 2; g++) sample(g);
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic begin_window(input string name);
      wname  = name;
      mon_en = 1'b1;
      cyc    = 0;
      sq0.delete(); sq1.delete(); eq0.delete(); eq1.delete();
      for (int g = 0; g < 2; g++) begin
         clr_cnt[g] = 0; done_cnt[g] = 0; busy_cnt[g] = 0;
         exp_busy[g] = 0; ops[g] = 0; hazard[g] = 1'b0;
      end
   endtask

   task automatic end_window();
      chk($sformatf("%s pending_upd[0]", wname), 64'(sq0.size()), 64'd0);
      chk($sformatf("%s pending_upd[1]", wname), 64'(sq1.size()), 64'd0);
      chk($sformatf("%s pending_done[0]", wname), 64'(eq0.size()), 64'd0);
      chk($sformatf("%s pending_done[1]", wname), 64'(eq1.size()), 64'd0);
      for (int g = 0; g < 2; g++) begin
         chk($sformatf("%s done_count[%0d]", wname, g), 64'(done_cnt[g]), 64'(ops[g]));
         chk($sformatf("%s clr_count[%0d]", wname, g), 64'(clr_cnt[g]), 64'(ops[g]));
         chk($sformatf("%s busy_cycles[%0d]", wname, g), 64'(busy_cnt[g]), 64'(exp_busy[g]));
         chk($sformatf("%s upd_clr_overlap[%0d]", wname, g), 64'(hazard[g]), 64'd0);
      end
      mon_en = 1'b0;
   endtask

   // One operation started by a single-cycle pulse; optional stray start during cycle 2.
   task automatic run_single(input logic [31:0] ra, input logic [31:0] rb, input logic [63:0] p,
                             input int steps0, input bit poke, input string name);
      begin_window(name);
      a = ra;
      b = rb;
      start = 1'b1;
      expect_op(ra, rb, p, steps0, 0);
      step();
      for (int c = 1; c < 8; c++) begin
         start = poke && (c == 2);
         step();
      end
      start = 1'b0;
      end_window();
   endtask

   initial begin
      #100000;
      $display("FAIL global timeout");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{32'h0000_0003, 32'h0000_0005, 64'h0000_0000_0000_000F, 1, 1'b0, "small"};
      vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 4, 1'b0, "max"};
      vecs[2] = '{32'h0001_0000, 32'h0000_0002, 64'h0000_0000_0002_0000, 2, 1'b0, "a_msw_only"};
      vecs[3] = '{32'h0000_0005, 32'h0003_0000, 64'h0000_0000_000F_0000, 2, 1'b0, "b_msw_only"};
      vecs[4] = '{32'h0000_0000, 32'h0000_0000, 64'h0000_0000_0000_0000, 1, 1'b0, "zero"};
      vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 4, 1'b1, "start_in_p01"};

      mon_en = 1'b0;
      reset  = 1'b0;
      start  = 1'b1;
      a      = 32'h0000_0003;
      b      = 32'h0000_0005;
      @(negedge clk);
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         chk($sformatf("reset busy[%0d]", g), 64'(busy_v[g]), 64'd0);
         chk($sformatf("reset done[%0d]", g), 64'(done_v[g]), 64'd0);
         chk($sformatf("reset a_sel[%0d]", g), 64'(a_sel_v[g]), 64'd0);
         chk($sformatf("reset b_sel[%0d]", g), 64'(b_sel_v[g]), 64'd0);
         chk($sformatf("reset shift_sel[%0d]", g), 64'(shift_all[g*2 +: 2]), 64'd0);
         chk($sformatf("reset upd_prod[%0d]", g), 64'(upd_v[g]), 64'd0);
         chk($sformatf("reset clr_prod[%0d]", g), 64'(clr_v[g]), 64'd0);
         chk($sformatf("reset steps[%0d]", g), 64'(steps_all[g*3 +: 3]), 64'd0);
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      reset = 1'b1;
      step();

      for (int i = 0; i < 6; i++) begin
         run_single(vecs[i].a, vecs[i].b, vecs[i].prod, vecs[i].steps, vecs[i].poke, vecs[i].name);
      end

      // start held high across two operations, operands swapped in the IDLE cycle between them
      begin_window("back_to_back");
      a = 32'h1234_5678;
      b = 32'h9ABC_DEF0;
      start = 1'b1;
      expect_op(a, b, 64'h0B00_EA4E_242D_2080, 4, 0);
      for (int c = 0; c < 6; c++) step();
      a = 32'd7;
      b = 32'd6;
      expect_op(a, b, 64'h0000_0000_0000_002A, 1, 6);
      step();
      start = 1'b0;
      for (int c = 7; c < 14; c++) step();
      end_window();

      for (int i = 0; i < 24; i++) begin
         logic [31:0] ra, rb;
         ra = $urandom;
         rb = $urandom;
         if ($urandom_range(0, 2) == 0) ra = ra & 32'h0000_FFFF;
         if ($urandom_range(0, 2) == 0) rb = rb & 32'h0000_FFFF;
         if ($urandom_range(0, 5) == 0) ra = ra & 32'hFFFF_0000;
         run_single(ra, rb, {32'h0, ra} * {32'h0, rb}, model_steps(ra, rb, 1'b1),
                    bit'($urandom_range(0, 1)), $sformatf("rand%0d", i));
      end

      // Asynchronous reset while both instances sit in P10
      mon_en = 1'b0;
      a = 32'hFFFF_FFFF;
      b = 32'hFFFF_0001;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      chk("pre_abort upd_prod", 64'(upd_v), 64'h3);
      chk("pre_abort a_sel", 64'(a_sel_v), 64'h3);
      chk("pre_abort b_sel", 64'(b_sel_v), 64'h0);
      #2;
      reset = 1'b0;
      #1;
      chk("abort busy", 64'(busy_v), 64'h0);
      chk("abort upd_prod", 64'(upd_v), 64'h0);
      chk("abort done", 64'(done_v), 64'h0);
      chk("abort steps", 64'(steps_all), 64'h0);
      step();
      step();
      chk("abort hold busy", 64'(busy_v), 64'h0);
      chk("abort hold done", 64'(done_v), 64'h0);
      reset = 1'b1;
      step();
      run_single(32'hABCD_1234, 32'h0000_0099, 64'(32'hABCD_1234) * 64'(32'h0000_0099),
                 2, 1'b0, "after_abort");

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
